pid_pwm_out: RTL and testbench
==============================

PID_PWM_OUT -- requirements
Module: pid_pwm_out

Interface
REQ-001 SHALL have parameter CNT_W, default 6, PWM period counter width; period = 2^CNT_W clocks.
REQ-002 SHALL have parameter SLEW_STEP, default 8, max change of active duty per period, in duty counts.
REQ-003 SHALL have parameter DEAD_CYC, default 4, clocks with output forced off on a direction reversal.
REQ-004 SHALL have parameter MIN_PULSE, default 3, active duties 1..MIN_PULSE-1 are suppressed to zero output.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-007 SHALL have port ena  input  1  block enable; low forces IDLE.
REQ-008 SHALL have port u  input  6  PID controller output, two's-complement signed, -32..+31.
REQ-009 SHALL have port u_valid  input  1  one-cycle strobe qualifying u.
REQ-010 SHALL have port pwm_out  output  1  registered PWM drive, magnitude only.
REQ-011 SHALL have port dir_out  output  1  registered direction: 0 = positive, 1 = negative.
REQ-012 SHALL have port period_start  output  1  registered one-cycle pulse at counter value 0 in RUN.
REQ-013 SHALL have port sat_flag  output  1  registered; set when the last captured u was -32.

Function
REQ-014 SHALL capture u into a pending register on any edge with u_valid=1 and ena=1; last capture in a period wins.
REQ-015 SHALL derive target sign = u[5] and target magnitude = |u|, saturating -32 to 31; target duty = magnitude*2 (0..62).
REQ-016 SHALL implement states IDLE, RUN, DEAD.
REQ-017 IDLE -> RUN when ena=1; counter starts at 0 on the first RUN cycle.
REQ-018 In RUN the counter SHALL increment every clock, wrapping 2^CNT_W-1 -> 0; the wrap edge is the period boundary.
REQ-019 At each boundary the active duty SHALL move toward the pending target by at most SLEW_STEP, never overshooting.
REQ-020 If pending sign differs from dir_out and active duty > 0, the active duty SHALL slew toward 0 instead of toward the target.
REQ-021 If pending sign differs from dir_out, target magnitude > 0 and active duty = 0 at a boundary, the FSM SHALL enter DEAD.
REQ-022 DEAD SHALL last exactly DEAD_CYC clocks with pwm_out=0; on exit, dir_out toggles, counter = 0, state RUN, slew resumes from 0.
REQ-023 In RUN, pwm_out SHALL be high for exactly d_act consecutive clocks starting with the period_start cycle when d_act >= MIN_PULSE, otherwise low all period.
REQ-024 u_valid on the boundary edge SHALL NOT affect that boundary; the value is applied at the following boundary.
REQ-025 ena low SHALL move to IDLE on the next edge: pwm_out=0, period_start=0, counter=0, d_act=0; dir_out and pending are held.
REQ-026 u_valid during DEAD SHALL be captured; it is evaluated at the first boundary after DEAD.
REQ-027 Mid-period pending changes SHALL NOT alter the current period's pulse width.

Reset
REQ-028 With rst_n=0 at an edge: state IDLE, counter 0, d_act 0, pending 0, pwm_out 0, dir_out 0, period_start 0, sat_flag 0; rst_n has priority over ena and u_valid.

Structure
REQ-029 Package pid_pkg SHALL hold the state enum and default values of CNT_W, SLEW_STEP, DEAD_CYC, MIN_PULSE.
REQ-030 Slew arithmetic SHALL be a single combinational sub-module pid_slew_step (inputs active, target, step; output next duty); the rest is flat.

Verification (defaults)
REQ-031 Reset, ena=1, u=+10 strobed -> high widths 8, 16, 20, 20 clocks in successive periods; dir_out=0.
REQ-032 Steady d_act=20, then u=-6 -> widths 12, 4, 0; DEAD 4 clocks; dir_out=1; then widths 8, 12, 12.
REQ-033 u=+1 (target 2 < MIN_PULSE) -> pwm_out stays 0, period_start pulses every 64 clocks.
REQ-034 u=-32 -> sat_flag=1, dir reversal via DEAD, final width 62; then u=+5 -> sat_flag=0.
REQ-035 u_valid with u=+20 on the wrap edge while pending=+10 -> that boundary slews toward 20; the +20 target is applied at the next boundary.
REQ-036 ena dropped mid-pulse -> pwm_out 0 next clock; ena re-raised -> widths restart from 8.

Source files
------------

// File: rtl/pid_pkg.sv
// rtl/pid_pkg.sv - shared state type, parameter defaults and magnitude helper for pid_pwm_out
package pid_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } pid_state_t;

    localparam int CNT_W_DEF     = 6;
    localparam int SLEW_STEP_DEF = 8;
    localparam int DEAD_CYC_DEF  = 4;
    localparam int MIN_PULSE_DEF = 3;

    localparam logic [5:0] U_NEG_SAT = 6'b100000;

    // |v| for a 6-bit two's-complement value, with -32 clamped to 31
    function automatic logic [4:0] u_mag(input logic [5:0] v);
        logic [5:0] neg;
        neg = -v;
        if (v == U_NEG_SAT) begin
            return 5'd31;
        end else if (v[5]) begin
            return neg[4:0];
        end else begin
            return v[4:0];
        end
    endfunction

endpackage

// File: rtl/pid_slew_step.sv
// rtl/pid_slew_step.sv - moves a duty toward a target by at most one step, never overshooting
module pid_slew_step #(
    parameter int DW = 6
) (
    input  logic [DW-1:0] active,
    input  logic [DW-1:0] target,
    input  logic [DW-1:0] step,
    output logic [DW-1:0] next_duty
);

    logic [DW-1:0] diff;

    always_comb begin
        next_duty = active;
        diff      = '0;
        if (target > active) begin
            diff      = target - active;
            next_duty = (diff > step) ? active + step : target;
        end else if (target < active) begin
            diff      = active - target;
            next_duty = (diff > step) ? active - step : target;
        end
    end

endmodule

// File: rtl/pid_pwm_out.sv
// rtl/pid_pwm_out.sv - slew-limited sign/magnitude PWM driver with dead time on direction reversal
module pid_pwm_out
    import pid_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int SLEW_STEP = SLEW_STEP_DEF,
    parameter int DEAD_CYC  = DEAD_CYC_DEF,
    parameter int MIN_PULSE = MIN_PULSE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] u,
    input  logic       u_valid,
    output logic       pwm_out,
    output logic       dir_out,
    output logic       period_start,
    output logic       sat_flag
);

    localparam logic [5:0] STEP = 6'(SLEW_STEP);
    localparam logic [5:0] MIN_D = 6'(MIN_PULSE);
    localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
    localparam logic [DC_W-1:0] DEAD_LAST = DC_W'(DEAD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    pid_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       d_act;
    logic [5:0]       pend;
    logic [DC_W-1:0]  dead_cnt;

    logic [4:0] pend_mag;
    logic       next_dir;
    logic [5:0] slew_active;
    logic [5:0] slew_target;
    logic [5:0] slew_duty;
    logic       pulse_first;

    // Leaving DEAD is itself a boundary: slew starts from 0 in the new direction
    always_comb begin
        pend_mag    = u_mag(pend);
        next_dir    = (state == ST_DEAD) ? ~dir_out : dir_out;
        slew_active = (state == ST_DEAD) ? 6'd0 : d_act;
        slew_target = (pend[5] != next_dir) ? 6'd0 : {pend_mag, 1'b0};
        pulse_first = (slew_duty >= MIN_D) && (slew_duty != 6'd0);
    end

    pid_slew_step #(
        .DW(6)
    ) u_slew (
        .active   (slew_active),
        .target   (slew_target),
        .step     (STEP),
        .next_duty(slew_duty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            d_act        <= '0;
            pend         <= '0;
            dead_cnt     <= '0;
            pwm_out      <= 1'b0;
            dir_out      <= 1'b0;
            period_start <= 1'b0;
            sat_flag     <= 1'b0;
        end else begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            if (ena && u_valid) begin
                pend     <= u;
                sat_flag <= (u == U_NEG_SAT);
            end
            if (!ena) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                d_act    <= '0;
                dead_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state        <= ST_RUN;
                        cnt          <= '0;
                        d_act        <= '0;
                        period_start <= 1'b1;
                    end
                    ST_RUN: begin
                        cnt <= cnt + CNT_W'(1);
                        if (cnt == CNT_MAX) begin
                            if (pend[5] != dir_out && d_act == 6'd0 && pend_mag != 5'd0) begin
                                state    <= ST_DEAD;
                                dead_cnt <= DEAD_LAST;
                            end else begin
                                d_act        <= slew_duty;
                                period_start <= 1'b1;
                                pwm_out      <= pulse_first;
                            end
                        end else begin
                            pwm_out <= (d_act >= MIN_D) && (32'(cnt) + 32'd1 < 32'(d_act));
                        end
                    end
                    ST_DEAD: begin
                        if (dead_cnt == '0) begin
                            state        <= ST_RUN;
                            dir_out      <= ~dir_out;
                            cnt          <= '0;
                            d_act        <= slew_duty;
                            period_start <= 1'b1;
                            pwm_out      <= pulse_first;
                        end else begin
                            dead_cnt <= dead_cnt - DC_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pid_pwm_out.sv
// tb/tb_pid_pwm_out.sv - scoreboard bench: expected per-period width/length/dir queued with stimulus
module tb_pid_pwm_out;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [5:0] u;
    logic       u_valid;
    logic       pwm_out;
    logic       dir_out;
    logic       period_start;
    logic       sat_flag;

    typedef struct {
        int width;
        int len;
        int dir;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    pid_pwm_out dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .u           (u),
        .u_valid     (u_valid),
        .pwm_out     (pwm_out),
        .dir_out     (dir_out),
        .period_start(period_start),
        .sat_flag    (sat_flag)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void expect_period(input int w, input int l, input int d);
        exp_t e;
        e.width = w;
        e.len   = l;
        e.dir   = d;
        exp_q.push_back(e);
    endfunction

    task automatic strobe(input logic [5:0] val);
        @(posedge clk); #2;
        u       = val;
        u_valid = 1'b1;
        @(posedge clk); #2;
        u_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 1500) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_ps(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_start && n < 200);
        if (!period_start) chk({tag, "_ps_timeout"}, 0, 1);
    endtask

    // Period monitor: a period runs from one period_start to the next
    initial begin
        int   hi   = 0;
        int   len  = 0;
        int   pdir = 0;
        int   pnum = 0;
        bit   in_p = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n || !ena) begin
                in_p = 1'b0;
            end else if (period_start) begin
                if (in_p && exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("width_p%0d", pnum), hi, e.width);
                    chk($sformatf("len_p%0d", pnum), len, e.len);
                    chk($sformatf("dir_p%0d", pnum), pdir, e.dir);
                    pnum++;
                end
                in_p = 1'b1;
                hi   = int'(pwm_out);
                len  = 1;
                pdir = int'(dir_out);
            end else if (in_p) begin
                hi += int'(pwm_out);
                len++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        ena     = 1'b0;
        u       = '0;
        u_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        ena     = 1'b1;
        u_valid = 1'b1;
        u       = 6'b100000;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_dir", int'(dir_out), 0);
        chk("rst_ps", int'(period_start), 0);
        chk("rst_sat", int'(sat_flag), 0);

        // Ramp from reset: first period idle at 0, then 8, 16, 20, 20
        #2;
        u_valid = 1'b0;
        u       = '0;
        expect_period(0, 64, 0);
        expect_period(8, 64, 0);
        expect_period(16, 64, 0);
        expect_period(20, 64, 0);
        expect_period(20, 64, 0);
        rst_n = 1'b1;
        strobe(6'd10);
        wait_drain("ramp");

        // Reversal to -6 via DEAD
        expect_period(20, 64, 0);
        expect_period(12, 64, 0);
        expect_period(4, 64, 0);
        expect_period(0, 68, 0);
        expect_period(8, 64, 1);
        expect_period(12, 64, 1);
        expect_period(12, 64, 1);
        strobe(6'(-6));
        wait_drain("rev_neg");

        // +1: duty 2 is below MIN_PULSE, periods keep ticking
        expect_period(12, 64, 1);
        expect_period(4, 64, 1);
        expect_period(0, 68, 1);
        expect_period(0, 64, 0);
        expect_period(0, 64, 0);
        expect_period(0, 64, 0);
        strobe(6'd1);
        wait_drain("min_pulse");

        // -32 saturates to magnitude 31, duty 62
        expect_period(0, 64, 0);
        expect_period(0, 68, 0);
        for (int k = 1; k <= 7; k++) expect_period(8 * k, 64, 1);
        expect_period(62, 64, 1);
        expect_period(62, 64, 1);
        strobe(6'b100000);
        @(negedge clk);
        chk("sat_set", int'(sat_flag), 1);
        wait_drain("sat");
        strobe(6'd5);
        @(negedge clk);
        chk("sat_clr", int'(sat_flag), 0);

        // Reset mid-run has priority over ena/u_valid
        @(posedge clk); #2;
        rst_n   = 1'b0;
        u_valid = 1'b1;
        u       = 6'b100000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst2_pwm", int'(pwm_out), 0);
        chk("rst2_dir", int'(dir_out), 0);
        chk("rst2_ps", int'(period_start), 0);
        chk("rst2_sat", int'(sat_flag), 0);
        @(posedge clk); #2;
        u_valid = 1'b0;

        // Strobe on the wrap edge only takes effect one boundary later
        expect_period(0, 64, 0);
        expect_period(8, 64, 0);
        expect_period(16, 64, 0);
        expect_period(20, 64, 0);
        expect_period(28, 64, 0);
        expect_period(36, 64, 0);
        expect_period(40, 64, 0);
        expect_period(40, 64, 0);
        rst_n = 1'b1;
        wait_ps("wrap_first");
        strobe(6'd10);
        wait_ps("wrap_second");
        wait_ps("wrap_third");
        repeat (63) @(posedge clk);
        #2;
        u       = 6'd20;
        u_valid = 1'b1;
        @(posedge clk); #2;
        u_valid = 1'b0;
        @(negedge clk);
        chk("wrap_aligned", int'(period_start), 1);
        wait_drain("wrap");

        // Drop ena mid-pulse, strobe while disabled is ignored, then restart
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("ena_mid_pulse", int'(pwm_out), 1);
        @(posedge clk); #2;
        ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ena_off_pwm", int'(pwm_out), 0);
        chk("ena_off_ps", int'(period_start), 0);
        chk("ena_off_dir", int'(dir_out), 0);
        strobe(6'(-10));
        repeat (3) @(posedge clk);
        expect_period(0, 64, 0);
        expect_period(8, 64, 0);
        expect_period(16, 64, 0);
        expect_period(24, 64, 0);
        #2;
        ena = 1'b1;
        wait_drain("restart");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
